corner_collector: RTL and testbench

Downstream consumer of the Check4 score stream in the feature-detection pipeline. Tracks the active-pixel coordinates of every valid beat, compares each score against a runtime threshold, and pushes the coordinates of passing pixels into a first-word-fall-through FIFO. A ready/valid read port drains the FIFO. A per-frame detection count is latched at end of frame for the host/overlay logic.

---
 rtl/corner_collector_if.sv | 33 +++
 rtl/corner_collector.sv | 132 +++++++++++++
 tb/tb_corner_collector.sv | 255 +++++++++++++++++++++++++
 3 files changed

// File: rtl/corner_collector_if.sv
// ============================================================================
// Module : corner_collector_if
// Brief  : Score-stream input, FIFO read port and frame status bundle for
//          corner_collector.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

interface corner_collector_if;
    logic [7:0]  din;
    logic        valid;
    logic [7:0]  thresh;
    logic        rd_ready;
    logic        rd_valid;
    logic [9:0]  rd_x;
    logic [9:0]  rd_y;
    logic [7:0]  rd_score;
    logic [15:0] frame_count;
    logic        frame_done;
    logic        overflow;

    modport slave (
        input  din, valid, thresh, rd_ready,
        output rd_valid, rd_x, rd_y, rd_score, frame_count, frame_done, overflow
    );

    modport master (
        output din, valid, thresh, rd_ready,
        input  rd_valid, rd_x, rd_y, rd_score, frame_count, frame_done, overflow
    );
endinterface

`default_nettype wire

// File: rtl/corner_collector.sv
// ============================================================================
// Module : corner_collector
// Brief  : Thresholds the Check4 score stream, queues passing pixel coordinates
//          in a FWFT FIFO and latches a per-frame detection count.
//          Define CORNER_SCORE_EN to store and present the score per entry.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module corner_collector #(
    parameter int H_ACTIVE   = 800,
    parameter int V_ACTIVE   = 600,
    parameter int FIFO_DEPTH = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    corner_collector_if.slave bus
);

    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int CNT_W = PTR_W + 1;
`ifdef CORNER_SCORE_EN
    localparam int ENTRY_W = 28;
`else
    localparam int ENTRY_W = 20;
`endif
    localparam logic [9:0]       X_LAST   = 10'(H_ACTIVE - 1);
    localparam logic [9:0]       Y_LAST   = 10'(V_ACTIVE - 1);
    localparam logic [CNT_W-1:0] FULL_OCC = CNT_W'(FIFO_DEPTH);

    logic [9:0]         x_q, x_d, y_q, y_d;
    logic [15:0]        run_cnt_q, run_cnt_d;
    logic [15:0]        frame_count_q, frame_count_d;
    logic               frame_done_q, frame_done_d;
    logic               overflow_q, overflow_d;
    logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]   occ_q, occ_d;
    logic [ENTRY_W-1:0] mem_q [FIFO_DEPTH];

    logic               hit, last_beat, empty, full, push, pop, drop;
    logic [15:0]        run_inc;
    logic [ENTRY_W-1:0] wr_entry, head;

    always_comb begin
        hit       = bus.valid && (bus.thresh != 8'd0) && (bus.din >= bus.thresh);
        last_beat = bus.valid && (x_q == X_LAST) && (y_q == Y_LAST);
        empty     = (occ_q == '0);
        full      = (occ_q == FULL_OCC);
        pop       = !empty && bus.rd_ready;
        // A pop in the same cycle frees the slot the push needs.
        push      = hit && (!full || pop);
        drop      = hit && full && !pop;
        run_inc   = (hit && run_cnt_q != 16'hFFFF) ? run_cnt_q + 16'd1 : run_cnt_q;

        x_d = x_q;
        y_d = y_q;
        if (bus.valid) begin
            if (x_q == X_LAST) begin
                x_d = 10'd0;
                y_d = (y_q == Y_LAST) ? 10'd0 : y_q + 10'd1;
            end else begin
                x_d = x_q + 10'd1;
            end
        end

        run_cnt_d     = last_beat ? 16'd0 : run_inc;
        frame_count_d = last_beat ? run_inc : frame_count_q;
        frame_done_d  = last_beat;
        overflow_d    = drop ? 1'b1 : (frame_done_q ? 1'b0 : overflow_q);

        wr_ptr_d = push ? wr_ptr_q + PTR_W'(1) : wr_ptr_q;
        rd_ptr_d = pop  ? rd_ptr_q + PTR_W'(1) : rd_ptr_q;
        case ({push, pop})
            2'b10:   occ_d = occ_q + CNT_W'(1);
            2'b01:   occ_d = occ_q - CNT_W'(1);
            default: occ_d = occ_q;
        endcase

`ifdef CORNER_SCORE_EN
        wr_entry = {x_q, y_q, bus.din};
`else
        wr_entry = {x_q, y_q};
`endif
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            x_q           <= '0;
            y_q           <= '0;
            run_cnt_q     <= '0;
            frame_count_q <= '0;
            frame_done_q  <= 1'b0;
            overflow_q    <= 1'b0;
            wr_ptr_q      <= '0;
            rd_ptr_q      <= '0;
            occ_q         <= '0;
        end else begin
            x_q           <= x_d;
            y_q           <= y_d;
            run_cnt_q     <= run_cnt_d;
            frame_count_q <= frame_count_d;
            frame_done_q  <= frame_done_d;
            overflow_q    <= overflow_d;
            wr_ptr_q      <= wr_ptr_d;
            rd_ptr_q      <= rd_ptr_d;
            occ_q         <= occ_d;
        end
    end

    // Storage needs no reset: the occupancy count gates every read.
    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wr_ptr_q] <= wr_entry;
        end
    end

    assign head             = mem_q[rd_ptr_q];
    assign bus.rd_valid     = !empty;
    assign bus.rd_x         = empty ? 10'd0 : head[ENTRY_W-1 -: 10];
    assign bus.rd_y         = empty ? 10'd0 : head[ENTRY_W-11 -: 10];
`ifdef CORNER_SCORE_EN
    assign bus.rd_score     = empty ? 8'd0 : head[7:0];
`else
    assign bus.rd_score     = 8'h00;
`endif
    assign bus.frame_count  = frame_count_q;
    assign bus.frame_done   = frame_done_q;
    assign bus.overflow     = overflow_q;

endmodule

`default_nettype wire

// File: tb/tb_corner_collector.sv
// Directed bench for corner_collector on an 8x4 frame with a 4-entry FIFO.
`default_nettype none

module tb_corner_collector;
    logic clk;
    logic rst_n;
    int   n_vec;
    int   n_err;
    int   pops, dones, pop_x, pop_y;

    corner_collector_if ifc ();

    corner_collector #(.H_ACTIVE(8), .V_ACTIVE(4), .FIFO_DEPTH(4)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (ifc.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic cyc(input logic v, input logic [7:0] d);
        ifc.valid = v;
        ifc.din   = d;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset;
        rst_n = 1'b1;
        ifc.valid = 1'b0; ifc.din = 8'd0; ifc.thresh = 8'd0; ifc.rd_ready = 1'b0;
        #3 rst_n = 1'b0;
        #2;
        n_vec++;
        if ({ifc.rd_valid, ifc.rd_x, ifc.rd_y, ifc.rd_score} !== 29'd0) begin
            n_err++;
            $display("FAIL reset_read_port: got v=%b x=%0d y=%0d s=%0d, want all 0",
                     ifc.rd_valid, ifc.rd_x, ifc.rd_y, ifc.rd_score);
        end
        n_vec++;
        if ({ifc.frame_count, ifc.frame_done, ifc.overflow} !== 18'd0) begin
            n_err++;
            $display("FAIL reset_status: got cnt=%0d done=%b ovf=%b, want 0 0 0",
                     ifc.frame_count, ifc.frame_done, ifc.overflow);
        end
        @(posedge clk); @(posedge clk); #1;
        rst_n = 1'b1;
    endtask

    task automatic test_single_hit;
        ifc.thresh = 8'd100; ifc.rd_ready = 1'b1;
        pops = 0; dones = 0; pop_x = -1; pop_y = -1;
        for (int y = 0; y < 4; y++) begin
            for (int x = 0; x < 8; x++) begin
                cyc(1'b1, (x == 3 && y == 2) ? 8'd200 : 8'd50);
                if (ifc.rd_valid) begin pops++; pop_x = ifc.rd_x; pop_y = ifc.rd_y; end
                if (ifc.frame_done) dones++;
                if (x == 7 && y == 3) begin
                    n_vec++;
                    if (ifc.frame_done !== 1'b1 || ifc.frame_count !== 16'd1) begin
                        n_err++;
                        $display("FAIL single_frame_end: got done=%b cnt=%0d, want 1 1",
                                 ifc.frame_done, ifc.frame_count);
                    end
                end
            end
            for (int b = 0; b < 2; b++) begin
                cyc(1'b0, 8'd0);
                if (ifc.rd_valid) begin pops++; pop_x = ifc.rd_x; pop_y = ifc.rd_y; end
                if (ifc.frame_done) dones++;
            end
        end
        n_vec++;
        if (pops != 1 || pop_x != 3 || pop_y != 2) begin
            n_err++;
            $display("FAIL single_pop: got pops=%0d x=%0d y=%0d, want 1 3 2", pops, pop_x, pop_y);
        end
        n_vec++;
        if (dones != 1 || ifc.overflow !== 1'b0) begin
            n_err++;
            $display("FAIL single_done_count: got dones=%0d ovf=%b, want 1 0", dones, ifc.overflow);
        end
    endtask

    task automatic test_thresh_edges;
        ifc.thresh = 8'd128; ifc.rd_ready = 1'b0;
        cyc(1'b1, 8'd127);
        cyc(1'b1, 8'd128);
        cyc(1'b1, 8'd255);
        n_vec++;
        if (ifc.rd_valid !== 1'b1 || ifc.rd_x !== 10'd1 || ifc.rd_y !== 10'd0) begin
            n_err++;
            $display("FAIL thresh_first_hit: got v=%b x=%0d y=%0d, want 1 1 0",
                     ifc.rd_valid, ifc.rd_x, ifc.rd_y);
        end
        ifc.rd_ready = 1'b1;
        cyc(1'b0, 8'd0);
        n_vec++;
        if (ifc.rd_valid !== 1'b1 || ifc.rd_x !== 10'd2) begin
            n_err++;
            $display("FAIL thresh_second_hit: got v=%b x=%0d, want 1 2", ifc.rd_valid, ifc.rd_x);
        end
        cyc(1'b0, 8'd0);
        n_vec++;
        if (ifc.rd_valid !== 1'b0 || ifc.rd_x !== 10'd0) begin
            n_err++;
            $display("FAIL thresh_drained: got v=%b x=%0d, want 0 0", ifc.rd_valid, ifc.rd_x);
        end
        for (int i = 3; i < 32; i++) cyc(1'b1, 8'd0);
        n_vec++;
        if (ifc.frame_done !== 1'b1 || ifc.frame_count !== 16'd2) begin
            n_err++;
            $display("FAIL thresh_count: got done=%b cnt=%0d, want 1 2", ifc.frame_done, ifc.frame_count);
        end
        ifc.thresh = 8'd0; ifc.rd_ready = 1'b0;
        pops = 0;
        for (int i = 0; i < 32; i++) begin
            cyc(1'b1, 8'd255);
            if (ifc.rd_valid) pops++;
        end
        n_vec++;
        if (pops != 0 || ifc.frame_count !== 16'd0 || ifc.frame_done !== 1'b1) begin
            n_err++;
            $display("FAIL thresh_zero: got valid_cycles=%0d cnt=%0d done=%b, want 0 0 1",
                     pops, ifc.frame_count, ifc.frame_done);
        end
    endtask

    task automatic test_overflow;
        ifc.thresh = 8'd10; ifc.rd_ready = 1'b0;
        for (int i = 0; i < 6; i++) begin
            cyc(1'b1, 8'd50);
            if (i == 3 || i == 4) begin
                n_vec++;
                if (ifc.overflow !== (i == 4)) begin
                    n_err++;
                    $display("FAIL ovf_set_beat%0d: got %b, want %b", i, ifc.overflow, (i == 4));
                end
            end
        end
        for (int i = 6; i < 32; i++) cyc(1'b1, 8'd0);
        n_vec++;
        if (ifc.frame_done !== 1'b1 || ifc.frame_count !== 16'd6 || ifc.overflow !== 1'b1) begin
            n_err++;
            $display("FAIL ovf_frame_end: got done=%b cnt=%0d ovf=%b, want 1 6 1",
                     ifc.frame_done, ifc.frame_count, ifc.overflow);
        end
        ifc.rd_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            n_vec++;
            if (ifc.rd_valid !== 1'b1 || ifc.rd_x !== 10'(i) || ifc.rd_y !== 10'd0) begin
                n_err++;
                $display("FAIL ovf_entry%0d: got v=%b x=%0d y=%0d, want 1 %0d 0",
                         i, ifc.rd_valid, ifc.rd_x, ifc.rd_y, i);
            end
            cyc(1'b0, 8'd0);
            if (i == 0) begin
                n_vec++;
                if (ifc.overflow !== 1'b0) begin
                    n_err++;
                    $display("FAIL ovf_clear: got %b, want 0", ifc.overflow);
                end
            end
        end
        n_vec++;
        if (ifc.rd_valid !== 1'b0) begin
            n_err++;
            $display("FAIL ovf_empty: got rd_valid=%b, want 0", ifc.rd_valid);
        end
    endtask

    task automatic test_full_pop;
        logic seen_ovf;
        seen_ovf = 1'b0;
        ifc.thresh = 8'd10; ifc.rd_ready = 1'b0;
        for (int i = 0; i < 4; i++) cyc(1'b1, 8'd50);
        ifc.rd_ready = 1'b1;
        for (int i = 4; i < 32; i++) begin
            cyc(1'b1, (i == 4) ? 8'd50 : 8'd0);
            seen_ovf = seen_ovf | ifc.overflow;
            if (i >= 4 && i <= 8) begin
                n_vec++;
                if (ifc.rd_valid !== (i != 8) || (i != 8 && ifc.rd_x !== 10'(i - 3))) begin
                    n_err++;
                    $display("FAIL fullpop_head_beat%0d: got v=%b x=%0d, want %b %0d",
                             i, ifc.rd_valid, ifc.rd_x, (i != 8), (i != 8) ? i - 3 : 0);
                end
            end
        end
        n_vec++;
        if (seen_ovf || ifc.frame_count !== 16'd5 || ifc.frame_done !== 1'b1) begin
            n_err++;
            $display("FAIL fullpop_frame: got ovf_seen=%b cnt=%0d done=%b, want 0 5 1",
                     seen_ovf, ifc.frame_count, ifc.frame_done);
        end
    endtask

    task automatic test_score;
        logic [7:0] exp_score;
`ifdef CORNER_SCORE_EN
        exp_score = 8'd201;
`else
        exp_score = 8'd0;
`endif
        ifc.thresh = 8'd200; ifc.rd_ready = 1'b0;
        for (int i = 0; i < 14; i++) cyc(1'b1, (i == 13) ? 8'd201 : 8'd0);
        n_vec++;
        if (ifc.rd_valid !== 1'b1 || ifc.rd_x !== 10'd5 || ifc.rd_y !== 10'd1 ||
            ifc.rd_score !== exp_score) begin
            n_err++;
            $display("FAIL score_entry: got v=%b x=%0d y=%0d s=%0d, want 1 5 1 %0d",
                     ifc.rd_valid, ifc.rd_x, ifc.rd_y, ifc.rd_score, exp_score);
        end
    endtask

    task automatic test_reset_midstream;
        #2 rst_n = 1'b0;
        #1;
        n_vec++;
        if ({ifc.rd_valid, ifc.rd_x, ifc.rd_y, ifc.rd_score, ifc.frame_count,
             ifc.frame_done, ifc.overflow} !== 47'd0) begin
            n_err++;
            $display("FAIL midreset_outputs: got v=%b x=%0d y=%0d s=%0d cnt=%0d done=%b ovf=%b, want all 0",
                     ifc.rd_valid, ifc.rd_x, ifc.rd_y, ifc.rd_score, ifc.frame_count,
                     ifc.frame_done, ifc.overflow);
        end
        @(posedge clk); #1;
        rst_n = 1'b1;
        ifc.thresh = 8'd1;
        cyc(1'b1, 8'd255);
        n_vec++;
        if (ifc.rd_valid !== 1'b1 || ifc.rd_x !== 10'd0 || ifc.rd_y !== 10'd0) begin
            n_err++;
            $display("FAIL midreset_first_beat: got v=%b x=%0d y=%0d, want 1 0 0",
                     ifc.rd_valid, ifc.rd_x, ifc.rd_y);
        end
    endtask

    initial begin
        n_vec = 0;
        n_err = 0;
        test_reset();
        test_single_hit();
        test_thresh_edges();
        test_overflow();
        test_full_pop();
        test_score();
        test_reset_midstream();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

`default_nettype wire
